// File: rtl/apb_mul_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_mul_regs : APB3 register front-end launching and collecting serial_multiplier results. Rev 1.0
// ---------------------------------------------------------------------------
module apb_mul_regs #(
  parameter int OP_X_WIDTH = 16,
  parameter int OP_Y_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             psel,
  input  logic                             penable,
  input  logic                             pwrite,
  input  logic [ADDR_WIDTH-1:0]            paddr,
  input  logic [31:0]                      pwdata,
  output logic [31:0]                      prdata,
  output logic                             pready,
  output logic                             pslverr,
  output logic                             mul_start,
  output logic [OP_X_WIDTH-1:0]            mul_x,
  output logic [OP_Y_WIDTH-1:0]            mul_y,
  input  logic                             mul_valid,
  input  logic [OP_X_WIDTH+OP_Y_WIDTH-1:0] mul_res,
  output logic                             irq
);

  localparam int RES_WIDTH = OP_X_WIDTH + OP_Y_WIDTH;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  localparam logic [2:0] IDX_OPX    = 3'd0;
  localparam logic [2:0] IDX_OPY    = 3'd1;
  localparam logic [2:0] IDX_CTRL   = 3'd2;
  localparam logic [2:0] IDX_STATUS = 3'd3;
  localparam logic [2:0] IDX_RES_LO = 3'd4;
  localparam logic [2:0] IDX_RES_HI = 3'd5;

  logic [1:0]            state;
  logic [OP_X_WIDTH-1:0] opx;
  logic [OP_Y_WIDTH-1:0] opy;
  logic                  ie;
  logic                  done;
  logic [RES_WIDTH-1:0]  result;

  logic [2:0]  idx;
  logic        access;
  logic        busy;
  logic        unmapped;
  logic        err;
  logic        wr_ok;
  logic        start_req;
  logic        clr_req;
  logic        capture;
  logic [63:0] res_ext;
  logic [31:0] opx_ext;
  logic [31:0] opy_ext;
  logic [31:0] rd_mux;

  assign idx      = paddr[4:2];
  assign access   = psel & penable;
  assign busy     = (state != ST_IDLE);
  assign unmapped = (idx > IDX_RES_HI);

  // Operand and control registers are locked while the multiplier is running.
  assign err       = access & (unmapped | (pwrite & busy & (idx <= IDX_CTRL)));
  assign wr_ok     = access & pwrite & ~err;
  assign start_req = wr_ok & (idx == IDX_CTRL) & pwdata[0];
  assign clr_req   = wr_ok & (idx == IDX_STATUS) & pwdata[1];
  assign capture   = (state == ST_WAIT) & mul_valid;

  assign pready    = 1'b1;
  assign pslverr   = err;
  assign mul_start = (state == ST_LAUNCH);
  assign mul_x     = opx;
  assign mul_y     = opy;
  assign irq       = done & ie;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opx <= '0;
      opy <= '0;
      ie  <= 1'b0;
    end else begin
      if (wr_ok && idx == IDX_OPX) opx <= pwdata[OP_X_WIDTH-1:0];
      if (wr_ok && idx == IDX_OPY) opy <= pwdata[OP_Y_WIDTH-1:0];
      if (wr_ok && idx == IDX_CTRL) ie <= pwdata[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start_req) state <= ST_LAUNCH;
        ST_LAUNCH: state <= ST_WAIT;
        ST_WAIT:   if (mul_valid) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // A completing multiplication wins over a same-edge DONE clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      if (capture) result <= mul_res;
      if (capture) begin
        done <= 1'b1;
      end else if (start_req || clr_req) begin
        done <= 1'b0;
      end
    end
  end

  always_comb begin
    res_ext = '0;
    res_ext[RES_WIDTH-1:0] = result;
    opx_ext = '0;
    opx_ext[OP_X_WIDTH-1:0] = opx;
    opy_ext = '0;
    opy_ext[OP_Y_WIDTH-1:0] = opy;
  end

  always_comb begin
    rd_mux = '0;
    case (idx)
      IDX_OPX:    rd_mux = opx_ext;
      IDX_OPY:    rd_mux = opy_ext;
      IDX_CTRL:   rd_mux = {30'd0, ie, 1'b0};
      IDX_STATUS: rd_mux = {30'd0, done, busy};
      IDX_RES_LO: rd_mux = res_ext[31:0];
      IDX_RES_HI: rd_mux = res_ext[63:32];
      default:    rd_mux = '0;
    endcase
  end

  assign prdata = (access & ~pwrite) ? rd_mux : 32'd0;

endmodule
`default_nettype wire
